// File: rtl/inst_sram_responder.sv
// Instruction-memory responder: preloads the on-chip array from a word stream, then serves
// fetch requests in the kseg1 boot window with one-cycle registered read-first latency.
module inst_sram_responder #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_en,
    input  logic [3:0]        inst_wen,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic [31:0]       inst,
    output logic              inst_err,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic [ADDR_W:0]   load_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     ptr;
    logic [3:0][7:0]     mem [DEPTH];

    logic                load_acc, load_end;
    logic                win_hit, aligned, req_ok;
    logic [ADDR_W-1:0]   idx;

    assign load_acc = (state == LOAD) && load_valid;
    assign load_end = load_last || (ptr[ADDR_W-1:0] == {ADDR_W{1'b1}});
    assign win_hit  = inst_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2];
    assign aligned  = inst_addr[1:0] == 2'b00;
    assign req_ok   = win_hit && aligned;
    assign idx      = inst_addr[ADDR_W+1:2];
    assign load_count = ptr;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        case (state)
            LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid && load_end) state_nxt = RUN;
            end
            RUN: state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)         ptr <= '0;
        else if (load_acc) ptr <= ptr + PTR_ONE;
    end

    // Array is never cleared; reset only blocks writes in the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_acc) begin
                mem[ptr[ADDR_W-1:0]] <= load_data;
            end else if (state == RUN && inst_en && req_ok) begin
                for (int i = 0; i < 4; i++)
                    if (inst_wen[i]) mem[idx][i] <= inst_wdata[8*i +: 8];
            end
        end
    end

    // Read-first: the nonblocking read sees the array before this edge's lane writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst     <= '0;
            inst_err <= 1'b0;
        end else if (state == RUN && inst_en) begin
            if (req_ok) begin
                inst     <= mem[idx];
                inst_err <= 1'b0;
            end else begin
                inst     <= '0;
                inst_err <= 1'b1;
            end
        end
    end
endmodule
